// File: rtl/data_memory_bridge.sv
// ---------------------------------------------------------------------------
// data_memory_bridge
//
// Memory-access-stage bridge between the pipeline's single-cycle data-memory
// strobes and a slower external word memory using a req/ack handshake. Each
// load/store is registered, issued as one handshake transaction, and the
// pipeline is held with o_Stall until the data returns or a timeout fires.
// Misaligned and timed-out accesses raise a sticky error flag.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   in_MemRead       load strobe from EX/MEM
//   in_MemWrite      store strobe from EX/MEM (wins over in_MemRead)
//   in_Address_dw    ALU byte address (only ADDR_WIDTH low bits are used)
//   in_WriteData_dw  store data
//   o_ReadData_dw    data of the most recently completed load
//   o_Stall          pipeline hold request
//   o_MemReq         memory request, held until ack or timeout
//   o_MemWe          1 = write transaction
//   o_MemAddr        registered byte address
//   o_MemWData       registered store data
//   in_MemAck        memory completion; read data valid in the same cycle
//   in_MemRData      memory read data
//   o_Error          sticky error flag, cleared only by reset
//   o_ErrCode        most recent error: 01 misaligned, 10 timeout
//   o_TxnCount       completed transactions (errored ones included), wraps
// ---------------------------------------------------------------------------
module data_memory_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_MemRead,
    input  logic                  in_MemWrite,
    input  logic [31:0]           in_Address_dw,
    input  logic [DATA_WIDTH-1:0] in_WriteData_dw,
    output logic [DATA_WIDTH-1:0] o_ReadData_dw,
    output logic                  o_Stall,
    output logic                  o_MemReq,
    output logic                  o_MemWe,
    output logic [ADDR_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0] o_MemWData,
    input  logic                  in_MemAck,
    input  logic [DATA_WIDTH-1:0] in_MemRData,
    output logic                  o_Error,
    output logic [1:0]            o_ErrCode,
    output logic [15:0]           o_TxnCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_error;
    logic [1:0]            r_errCode;
    logic [15:0]           r_txnCount;
    logic [7:0]            r_timer;

    logic                  w_strobe;
    logic                  w_misaligned;
    logic                  w_timeoutHit;
    logic                  w_stall;
    logic                  w_memReq;

    assign w_strobe     = in_MemRead | in_MemWrite;
    assign w_misaligned = |in_Address_dw[1:0];
    assign w_timeoutHit = (r_timer == TIMER_LAST);

    // Address bits above ADDR_WIDTH are deliberately dropped; fold them into
    // a dummy net so the discard is explicit.
    generate
        if (ADDR_WIDTH < 32) begin : g_addrDiscard
            logic w_unusedAddrBits;
            assign w_unusedAddrBits = ^in_Address_dw[31:ADDR_WIDTH];
        end
    endgenerate

    // State register. Asynchronous reset drops the FSM to IDLE at once,
    // which takes o_MemReq down without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. The stall is raised combinationally
    // in the IDLE cycle that sees a strobe so the pipeline never advances
    // past an access that has not completed. DONE is the single non-stalled
    // cycle in which the pipeline retires the instruction; any strobes seen
    // there still belong to that instruction and are ignored.
    always_comb begin
        w_nextState = r_state;
        w_stall     = 1'b0;
        w_memReq    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe) begin
                    w_stall     = 1'b1;
                    w_nextState = w_misaligned ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                w_stall  = 1'b1;
                w_memReq = 1'b1;
                if (in_MemAck || w_timeoutHit) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture the access on the IDLE edge, count REQ cycles, latch
    // load data or the error outcome, and count finished transactions in
    // DONE. Errored loads return zero so the write-back never sees stale
    // data; stores leave the read-data register untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
            r_errCode  <= 2'b00;
            r_txnCount <= 16'd0;
            r_timer    <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_strobe) begin
                        r_we    <= in_MemWrite;
                        r_addr  <= in_Address_dw[ADDR_WIDTH-1:0];
                        r_wdata <= in_WriteData_dw;
                        r_timer <= 8'd0;
                        if (w_misaligned) begin
                            r_error   <= 1'b1;
                            r_errCode <= 2'b01;
                            if (!in_MemWrite) begin
                                r_rdata <= '0;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (in_MemAck) begin
                        if (!r_we) begin
                            r_rdata <= in_MemRData;
                        end
                    end else if (w_timeoutHit) begin
                        r_error   <= 1'b1;
                        r_errCode <= 2'b10;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_txnCount <= r_txnCount + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // The stall is gated by reset so that an asserted reset releases the
    // pipeline even while a strobe is still being presented.
    assign o_Stall       = w_stall & reset;
    assign o_MemReq      = w_memReq;
    assign o_MemWe       = r_we;
    assign o_MemAddr     = r_addr;
    assign o_MemWData    = r_wdata;
    assign o_ReadData_dw = r_rdata;
    assign o_Error       = r_error;
    assign o_ErrCode     = r_errCode;
    assign o_TxnCount    = r_txnCount;

endmodule

// File: tb/tb_data_memory_bridge.sv
// ---------------------------------------------------------------------------
// tb_data_memory_bridge
//
// Drives load/store transactions into data_memory_bridge, plays the external
// memory (with a configurable number of wait states), and compares the
// bridge against a transaction-level model: each access is predicted as a
// whole (stall length, request length, read data, error state, count) from
// its address alignment, direction and the memory's ack delay.
// ---------------------------------------------------------------------------
module tb_data_memory_bridge;

    localparam int ADDR_WIDTH     = 8;
    localparam int DATA_WIDTH     = 32;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int MAX_CYCLES     = 400;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_MemRead;
    logic                  in_MemWrite;
    logic [31:0]           in_Address_dw;
    logic [DATA_WIDTH-1:0] in_WriteData_dw;
    logic [DATA_WIDTH-1:0] o_ReadData_dw;
    logic                  o_Stall;
    logic                  o_MemReq;
    logic                  o_MemWe;
    logic [ADDR_WIDTH-1:0] o_MemAddr;
    logic [DATA_WIDTH-1:0] o_MemWData;
    logic                  in_MemAck;
    logic [DATA_WIDTH-1:0] in_MemRData;
    logic                  o_Error;
    logic [1:0]            o_ErrCode;
    logic [15:0]           o_TxnCount;

    int checks = 0;
    int errors = 0;

    // Model memory (what the program believes is stored) and the memory the
    // responder actually serves; they only stay equal if stores arrive intact.
    logic [31:0] mem    [0:63];
    logic [31:0] extMem [0:63];

    logic [31:0] expRead;
    logic        expError;
    logic [1:0]  expCode;
    logic [15:0] expTxn;

    data_memory_bridge #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_MemRead     (in_MemRead),
        .in_MemWrite    (in_MemWrite),
        .in_Address_dw  (in_Address_dw),
        .in_WriteData_dw(in_WriteData_dw),
        .o_ReadData_dw  (o_ReadData_dw),
        .o_Stall        (o_Stall),
        .o_MemReq       (o_MemReq),
        .o_MemWe        (o_MemWe),
        .o_MemAddr      (o_MemAddr),
        .o_MemWData     (o_MemWData),
        .in_MemAck      (in_MemAck),
        .in_MemRData    (in_MemRData),
        .o_Error        (o_Error),
        .o_ErrCode      (o_ErrCode),
        .o_TxnCount     (o_TxnCount)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Compares every visible output against its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, " stall"},   32'(o_Stall),       32'd0);
        checkOutput({tag, " memReq"},  32'(o_MemReq),      32'd0);
        checkOutput({tag, " memWe"},   32'(o_MemWe),       32'd0);
        checkOutput({tag, " memAddr"}, 32'(o_MemAddr),     32'd0);
        checkOutput({tag, " wdata"},   o_MemWData,         32'd0);
        checkOutput({tag, " rdata"},   o_ReadData_dw,      32'd0);
        checkOutput({tag, " error"},   32'(o_Error),       32'd0);
        checkOutput({tag, " errCode"}, 32'(o_ErrCode),     32'd0);
        checkOutput({tag, " txn"},     32'(o_TxnCount),    32'd0);
    endtask

    // Runs one access from its IDLE cycle to the IDLE cycle after DONE.
    // Entered and left at one time unit after a rising edge. ackDelay is the
    // number of request cycles the memory lets pass before acking.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input int ackDelay, input string tag);
        int         stallCycles;
        int         reqCycles;
        int         cyc;
        int         expStall;
        int         expReq;
        logic [7:0] byteAddr;
        logic       isWrite;

        stallCycles = 0;
        reqCycles   = 0;
        cyc         = 0;
        byteAddr    = addr[7:0];
        isWrite     = wr;

        // Transaction-level prediction.
        if (byteAddr[1:0] != 2'b00) begin
            expStall = 1;
            expReq   = 0;
            expError = 1'b1;
            expCode  = 2'b01;
            if (!isWrite) expRead = 32'd0;
        end else if (ackDelay < TIMEOUT_CYCLES) begin
            expStall = 2 + ackDelay;
            expReq   = ackDelay + 1;
            if (isWrite) mem[byteAddr[7:2]] = wd;
            else         expRead = mem[byteAddr[7:2]];
        end else begin
            expStall = 1 + TIMEOUT_CYCLES;
            expReq   = TIMEOUT_CYCLES;
            expError = 1'b1;
            expCode  = 2'b10;
            if (!isWrite) expRead = 32'd0;
        end
        expTxn = expTxn + 16'd1;

        in_MemRead      = rd;
        in_MemWrite     = wr;
        in_Address_dw   = addr;
        in_WriteData_dw = wd;
        in_MemAck       = 1'b0;
        in_MemRData     = $urandom;
        #1;
        while (o_Stall === 1'b1 && cyc < MAX_CYCLES) begin
            stallCycles++;
            if (o_MemReq === 1'b1) begin
                checkOutput({tag, " req addr"},  32'(o_MemAddr), 32'(byteAddr));
                checkOutput({tag, " req we"},    32'(o_MemWe),   32'(isWrite));
                checkOutput({tag, " req wdata"}, o_MemWData,     wd);
                if (reqCycles == ackDelay) begin
                    in_MemAck = 1'b1;
                    if (o_MemWe) extMem[o_MemAddr[7:2]] = o_MemWData;
                    else         in_MemRData = extMem[o_MemAddr[7:2]];
                end else begin
                    in_MemAck   = 1'b0;
                    in_MemRData = $urandom;
                end
                reqCycles++;
            end else begin
                in_MemAck = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, " cycle bound"}, 32'(cyc >= MAX_CYCLES), 32'd0);

        // DONE cycle: pipeline advances; a stray ack here must be ignored.
        checkOutput({tag, " done memReq"}, 32'(o_MemReq), 32'd0);
        in_MemRead  = 1'b0;
        in_MemWrite = 1'b0;
        in_MemAck   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_MemAck = 1'b0;

        checkOutput({tag, " stall cycles"}, 32'(stallCycles), 32'(expStall));
        checkOutput({tag, " req cycles"},   32'(reqCycles),   32'(expReq));
        checkOutput({tag, " idle stall"},   32'(o_Stall),     32'd0);
        checkOutput({tag, " rdata"},        o_ReadData_dw,    expRead);
        checkOutput({tag, " error"},        32'(o_Error),     32'(expError));
        checkOutput({tag, " errCode"},      32'(o_ErrCode),   32'(expCode));
        checkOutput({tag, " txn"},          32'(o_TxnCount),  32'(expTxn));
    endtask

    initial begin
        logic [31:0] rAddr;
        logic        rRd;
        logic        rWr;
        int          rDelay;

        reset           = 1'b0;
        in_MemRead      = 1'b0;
        in_MemWrite     = 1'b0;
        in_Address_dw   = 32'd0;
        in_WriteData_dw = 32'd0;
        in_MemAck       = 1'b0;
        in_MemRData     = 32'd0;
        for (int i = 0; i < 64; i++) begin
            mem[i]    = $urandom;
            extMem[i] = mem[i];
        end
        mem[4]    = 32'h1234_5678;
        extMem[4] = 32'h1234_5678;
        expRead  = 32'd0;
        expError = 1'b0;
        expCode  = 2'b00;
        expTxn   = 16'd0;

        repeat (2) @(posedge clk);
        #1;
        checkResetState("inReset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("afterReset");

        $display("[TB] directed accesses");
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0,         0, "zeroWaitLoad");
        applyStimulus(1'b0, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 3, "storeWait3");
        applyStimulus(1'b1, 1'b0, 32'h0000_0013, 32'h0,         0, "misalignedLoad");
        applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_BEEF, 1, "bothStrobes");
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FF20, 32'h0,         2, "loadUpperIgnored");
        applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'h0,      1000, "timeoutLoad");
        applyStimulus(1'b1, 1'b0, 32'h0000_0034, 32'h0, TIMEOUT_CYCLES - 1, "ackLastCycle");
        applyStimulus(1'b0, 1'b1, 32'h0000_0038, 32'h1111_2222, TIMEOUT_CYCLES, "storeTimeout");
        applyStimulus(1'b0, 1'b1, 32'h0000_0039, 32'h3333_4444, 0, "misalignedStore");

        $display("[TB] random accesses");
        for (int n = 0; n < 40; n++) begin
            rAddr  = $urandom;
            rRd    = 1'($urandom_range(0, 1));
            rWr    = 1'($urandom_range(0, 1));
            rDelay = ($urandom_range(0, 7) == 0) ? TIMEOUT_CYCLES + 2 : $urandom_range(0, 4);
            if (!rRd && !rWr) rRd = 1'b1;
            if ($urandom_range(0, 5) != 0) rAddr[1:0] = 2'b00;
            applyStimulus(rRd, rWr, rAddr, $urandom, rDelay, "random");
        end

        $display("[TB] reset during request");
        in_MemRead    = 1'b1;
        in_Address_dw = 32'h0000_0008;
        in_MemAck     = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("midReq reqBefore", 32'(o_MemReq), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkResetState("midReqReset");
        in_MemRead = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        expRead  = 32'd0;
        expError = 1'b0;
        expCode  = 2'b00;
        expTxn   = 16'd0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h0000_0024, 32'h0, 0, "postResetLoad");

        // Stand in for 65535 earlier transactions, then retire one more.
        $display("[TB] transaction counter wrap");
        force dut.r_txnCount = 16'hFFFF;
        #1;
        release dut.r_txnCount;
        expTxn = 16'hFFFF;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h0000_0003, 32'h0, 0, "wrapTxn");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
